exec_muldiv: RTL and testbench

//   Multi-cycle HI/LO arithmetic unit in the execute stage, directly downstream of decode.

---
 rtl/exec_muldiv_pkg.sv | 25 ++
 rtl/exec_muldiv_mult_pipe.sv | 44 ++++
 rtl/exec_muldiv.sv | 106 ++++++++++
 tb/tb_exec_muldiv.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/exec_muldiv_pkg.sv
// exec_muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit
package exec_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    localparam int MD_DIV_CYCLES = 32;

    // Two's complement negate when n is set; used for |x| and the final sign fixup
    function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic n);
        return n ? 32'(-x) : x;
    endfunction

endpackage

// File: rtl/exec_muldiv_mult_pipe.sv
// exec_muldiv_mult_pipe: signed 33x33 multiplier with STAGES result registers and a valid chain
module exec_muldiv_mult_pipe #(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic        out_valid,
    output logic [63:0] p
);

    logic [STAGES-1:0] v_q, v_d;
    logic [63:0]       p_q [STAGES];
    logic [63:0]       p_d [STAGES];

    // Multiply into stage 0 and shift down the chain; low 64 bits of the
    // sign-extended product equal the low 64 bits of the true 66-bit product
    always_comb begin
        v_d[0] = in_valid && !flush;
        p_d[0] = {{31{a[32]}}, a} * {{31{b[32]}}, b};
        for (int i = 1; i < STAGES; i++) begin
            v_d[i] = v_q[i-1] && !flush;
            p_d[i] = p_q[i-1];
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) p_q[i] <= '0;
        end else begin
            v_q <= v_d;
            for (int i = 0; i < STAGES; i++) p_q[i] <= p_d[i];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign p         = p_q[STAGES-1];

endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi,lo} with a done pulse
module exec_muldiv
    import exec_muldiv_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  muldiv_op_t op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d, rem_sub;
    logic        negq_q, negq_d, negr_q, negr_d;
    logic        accept, is_mul, is_sgn, div_last, ge, fin, mul_v;
    logic [63:0] mul_p, res;

    assign accept   = start && !flush && (state_q == IDLE || state_q == DONE);
    assign is_mul   = op == MD_MULT || op == MD_MULTU;
    assign is_sgn   = op == MD_MULT || op == MD_DIV;
    assign div_last = cnt_q == 5'(MD_DIV_CYCLES - 1);

    exec_muldiv_mult_pipe #(.STAGES(MUL_STAGES)) u_mult (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .in_valid (accept && is_mul),
        .a        ({is_sgn & srca[31], srca}),
        .b        ({is_sgn & srcb[31], srcb}),
        .out_valid(mul_v),
        .p        (mul_p)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: flush dominates, then accept (also from DONE for back-to-back)
    always_comb begin
        state_d = state_q;
        if (flush)                                            state_d = IDLE;
        else if (accept)                                      state_d = is_mul ? (MUL_STAGES == 1 ? DONE : MUL) : DIV;
        else if (state_q == DONE)                             state_d = IDLE;
        else if (state_q == MUL && cnt_q == 5'(MUL_STAGES - 2)) state_d = DONE;
        else if (state_q == DIV && div_last)                  state_d = DONE;
    end

    // Status outputs decoded from state
    always_comb begin
        busy = state_q == MUL || state_q == DIV;
        done = state_q == DONE;
    end

    // Restoring divide step, counter, operand capture and HI/LO update
    always_comb begin
        ge      = acc_q[63] || acc_q[62:31] >= dvs_q;
        rem_sub = acc_q[62:31] - dvs_q;
        cnt_d   = accept ? '0 : busy ? cnt_q + 5'd1 : cnt_q;
        acc_d   = accept ? {32'b0, cond_neg(srca, is_sgn & srca[31])}
                : state_q == DIV ? {ge ? rem_sub : acc_q[62:31], acc_q[30:0], ge} : acc_q;
        dvs_d   = accept ? cond_neg(srcb, is_sgn & srcb[31]) : dvs_q;
        negq_d  = accept ? is_sgn & (srca[31] ^ srcb[31]) : negq_q;
        negr_d  = accept ? is_sgn & srca[31] : negr_q;
        res     = mul_v ? mul_p : {hi_q, lo_q};
        fin     = state_q == DIV && div_last && !flush;
        hi_d    = fin ? cond_neg(acc_d[63:32], negr_q) : res[63:32];
        lo_d    = fin ? cond_neg(acc_d[31:0], negq_q) : res[31:0];
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign hi = res[63:32];
    assign lo = res[31:0];

endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv: directed scoreboard bench for exec_muldiv
module tb_exec_muldiv;
    import exec_muldiv_pkg::*;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    muldiv_op_t  op = MD_MULT;
    logic [31:0] srca = '0, srcb = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total = 0;
    logic [63:0] exp_q[$];

    exec_muldiv #(.MUL_STAGES(MS)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Waits from cycle 1 for done, checking latency, busy span and the popped result
    task automatic wait_done(input int cyc, input string tag);
        int n = 1;
        int nb = 0;
        logic [63:0] e;
        while (!done && n < 100) begin
            if (busy) nb++;
            tick();
            n++;
        end
        e = exp_q.size() > 0 ? exp_q.pop_front() : 64'hx;
        chk({tag, " done_cycle"}, 64'(n), 64'(cyc));
        chk({tag, " busy_cycles"}, 64'(nb), 64'(cyc - 1));
        chk({tag, " busy_at_done"}, {63'b0, busy}, 64'd0);
        chk({tag, " result"}, {hi, lo}, e);
    endtask

    task automatic run(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e, input int cyc, input string tag);
        start = 1'b1; op = o; srca = a; srcb = b;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        chk({tag, " busy_after_accept"}, {63'b0, busy}, 64'd1);
        wait_done(cyc, tag);
    endtask

    initial begin
        int nd;
        logic [63:0] held;
        tick();
        chk("reset_outputs", {30'b0, busy, done, hi, lo}, 64'd0);
        resetn = 1'b1;
        tick();
        chk("idle_outputs", {30'b0, busy, done, hi, lo}, 64'd0);

        run(MD_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MS, "mult_neg");
        tick();
        chk("mult_done_one_cycle", {63'b0, done}, 64'd0);
        chk("mult_hold", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);

        run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MS, "multu_max");
        tick();
        run(MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, "div_neg7_2");
        tick();
        run(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, "div_min_m1");
        tick();
        run(MD_DIVU, 32'd10, 32'd0, 64'h0000000A_FFFFFFFF, 33, "divu_by0");
        run(MD_MULT, 32'd5, 32'd6, 64'h00000000_0000001E, MS, "mult_b2b");
        tick();
        chk("b2b_done_one_cycle", {63'b0, done}, 64'd0);

        held = {hi, lo};
        start = 1'b1; op = MD_DIV; srca = 32'd1000; srcb = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        chk("flush_hilo", {hi, lo}, held);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("flush_no_done", 64'(nd), 64'd0);

        start = 1'b1; flush = 1'b1; op = MD_DIVU; srca = 32'd9; srcb = 32'd2;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("flush_start_no_done", 64'(nd), 64'd0);
        chk("flush_start_hilo", {hi, lo}, held);

        start = 1'b1; op = MD_DIV; srca = 32'd77; srcb = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        chk("pre_reset_busy", {63'b0, busy}, 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_outputs", {30'b0, busy, done, hi, lo}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        run(MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "divu_after_reset");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
